// File: rtl/pipe_perf_monitor.sv
// Performance monitor for the pipelined CPU: counts run cycles, load-use stalls,
// flushes and retired instructions, halts after a cycle budget, and serves a 1-cycle readout port.
module pipe_perf_monitor #(
   parameter int unsigned MAX_CYCLES = 20,
   parameter int unsigned CNT_W      = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             stall_i,
   input  logic             branch_i,
   input  logic             jump_i,
   input  logic             flush_i,
   input  logic             retire_i,
   input  logic             clr_i,
   input  logic             rd_req_i,
   input  logic [1:0]       rd_sel_i,
   output logic             rd_ack_o,
   output logic [CNT_W-1:0] rd_data_o,
   output logic             running_o,
   output logic             halt_o
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_e;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [63:0]      MAX_LIM = 64'(MAX_CYCLES);
   localparam bit               HALT_EN = (MAX_CYCLES != 0);

   state_e                  state_q, state_d;
   logic [3:0][CNT_W-1:0]   cnt_q, cnt_d;
   logic [3:0]              inc;
   logic                    rd_ack_q, rd_ack_d;
   logic [CNT_W-1:0]        rd_data_q, rd_data_d;
   logic                    running_q, running_d;
   logic                    halt_q, halt_d;

   always_comb begin
      // counter index order matches rd_sel_i: cycles, stalls, flushes, retired
      inc       = {retire_i, flush_i, stall_i & ~branch_i & ~jump_i, 1'b1};
      cnt_d     = cnt_q;
      state_d   = state_q;
      rd_ack_d  = rd_req_i;
      rd_data_d = rd_data_q;
      if (rd_req_i) rd_data_d = cnt_q[rd_sel_i];
      if (clr_i) begin
         cnt_d   = '0;
         state_d = S_IDLE;
         if (rd_req_i) rd_data_d = '0;
      end else begin
         case (state_q)
            S_IDLE: if (start_i) state_d = S_RUN;
            S_RUN: begin
               for (int i = 0; i < 4; i++)
                  if (inc[i] && cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + CNT_W'(1);
               // budget check uses the post-edge count so the halting cycle is still counted
               if (HALT_EN && 64'(cnt_d[0]) == MAX_LIM) state_d = S_HALT;
               else if (!start_i)                        state_d = S_IDLE;
            end
            default: ;
         endcase
      end
      running_d = (state_d == S_RUN);
      halt_d    = (state_d == S_HALT);
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         rd_ack_q  <= 1'b0;
         rd_data_q <= '0;
         running_q <= 1'b0;
         halt_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rd_ack_q  <= rd_ack_d;
         rd_data_q <= rd_data_d;
         running_q <= running_d;
         halt_q    <= halt_d;
      end
   end

   assign rd_ack_o  = rd_ack_q;
   assign rd_data_o = rd_data_q;
   assign running_o = running_q;
   assign halt_o    = halt_q;

endmodule
